// File: rtl/phase_seq_driver.sv
// Phase-code transmitter: owns the global phase counter and emits one spike per
// phase cycle at the target popped from an internal FIFO.
module phase_seq_driver #(
    parameter int unsigned PERIOD     = 256,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  loop_mode,
    input  logic                  wr_valid,
    input  logic [7:0]            wr_phase,
    output logic                  wr_ready,
    output logic [7:0]            global_phase,
    output logic                  cycle_start,
    output logic                  spike_out,
    output logic                  fired_this_cycle,
    output logic [7:0]            phase_tx,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  underrun
);
    localparam int unsigned PH_W  = 8;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PH_W-1:0]       r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic [PH_W-1:0]       r_phase;
    logic [PH_W-1:0]       r_target;
    logic                  r_armed;
    logic                  r_cycle_start;
    logic                  r_spike;
    logic                  r_fired;
    logic [PH_W-1:0]       r_phase_tx;
    logic                  r_underrun;

    logic                  w_load;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic [PH_W-1:0]       w_head;
    logic [PH_W-1:0]       w_head_cl;
    logic                  w_repush;
    logic                  w_wr;
    logic                  w_push;
    logic [PH_W-1:0]       w_push_data;
    logic [PH_W-1:0]       w_phase_n;
    logic                  w_armed_n;
    logic [PH_W-1:0]       w_target_n;
    logic                  w_spike_n;

    // Next-state decode; a full FIFO still accepts a write on the edge it pops.
    always_comb begin
        w_load      = enable && (r_phase == LAST_PH);
        w_empty     = (r_count == '0);
        w_full      = (r_count == FULL_CNT);
        w_pop       = w_load && !w_empty;
        w_head      = r_mem[r_rptr];
        w_head_cl   = (w_head > LAST_PH) ? LAST_PH : w_head;
        w_repush    = w_pop && loop_mode;
        wr_ready    = !loop_mode && (!w_full || w_pop);
        w_wr        = wr_valid && wr_ready;
        w_push      = w_wr || w_repush;
        w_push_data = w_repush ? w_head_cl : wr_phase;
        w_phase_n   = w_load ? '0 : r_phase + PH_W'(1);
        w_armed_n   = w_load ? !w_empty : r_armed;
        w_target_n  = w_pop ? w_head_cl : r_target;
        w_spike_n   = enable && w_armed_n && (w_phase_n == w_target_n);
    end

    // FIFO storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_phase       <= LAST_PH;
            r_target      <= '0;
            r_armed       <= 1'b0;
            r_cycle_start <= 1'b0;
            r_spike       <= 1'b0;
            r_fired       <= 1'b0;
            r_phase_tx    <= '0;
            r_underrun    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
            r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_cycle_start <= w_load;
            r_underrun    <= w_load && w_empty;
            r_spike       <= w_spike_n;
            if (enable) begin
                r_phase  <= w_phase_n;
                r_target <= w_target_n;
                r_armed  <= w_armed_n && !w_spike_n;
            end
            // A target of 0 fires on the load edge itself, keeping the flag high.
            if (w_spike_n) begin
                r_fired    <= 1'b1;
                r_phase_tx <= w_target_n;
            end else if (w_load) begin
                r_fired    <= 1'b0;
            end
        end
    end

    assign global_phase     = r_phase;
    assign cycle_start      = r_cycle_start;
    assign spike_out        = r_spike;
    assign fired_this_cycle = r_fired;
    assign phase_tx         = r_phase_tx;
    assign fifo_count       = r_count;
    assign underrun         = r_underrun;

endmodule

// File: tb/tb_phase_seq_driver.sv
// Self-checking bench for phase_seq_driver: queue-based reference model checked
// every clock, plus directed sequences and a target table.
module tb_phase_seq_driver;
    localparam int PERIOD = 256;
    localparam int DEPTH  = 8;
    localparam int DL2    = 3;

    logic           clk;
    logic           rst_n;
    logic           enable;
    logic           loop_mode;
    logic           wr_valid;
    logic [7:0]     wr_phase;
    logic           wr_ready;
    logic [7:0]     global_phase;
    logic           cycle_start;
    logic           spike_out;
    logic           fired_this_cycle;
    logic [7:0]     phase_tx;
    logic [DL2:0]   fifo_count;
    logic           underrun;

    phase_seq_driver #(.PERIOD(PERIOD), .DEPTH(DEPTH), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .loop_mode(loop_mode),
        .wr_valid(wr_valid), .wr_phase(wr_phase), .wr_ready(wr_ready),
        .global_phase(global_phase), .cycle_start(cycle_start),
        .spike_out(spike_out), .fired_this_cycle(fired_this_cycle),
        .phase_tx(phase_tx), .fifo_count(fifo_count), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Reference model state
    int m_q[$];
    int m_phase;
    bit m_armed;
    int m_target;
    bit m_fired;
    int m_tx;
    bit e_cs;
    bit e_spike;
    bit e_under;
    bit m_acc;

    int sp_phase[$];
    bit sp_cs[$];
    int n_under_seen;

    typedef struct {
        logic [7:0] target;
        int         exp_phase;
        bit         exp_cs;
    } vec_t;
    vec_t tbl[8];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_phase  = PERIOD - 1;
        m_armed  = 0;
        m_target = 0;
        m_fired  = 0;
        m_tx     = 0;
        e_cs     = 0;
        e_spike  = 0;
        e_under  = 0;
    endfunction

    function automatic bit model_ready();
        return !loop_mode && (m_q.size() < DEPTH ||
               (enable && m_phase == PERIOD - 1 && m_q.size() > 0));
    endfunction

    function automatic void model_step();
        int v;
        bit acc;
        if (!rst_n) begin
            model_reset();
            m_acc = 0;
            return;
        end
        acc     = wr_valid && model_ready();
        e_cs    = 0;
        e_spike = 0;
        e_under = 0;
        if (enable) begin
            if (m_phase == PERIOD - 1) begin
                m_phase = 0;
                e_cs    = 1;
                m_fired = 0;
                if (m_q.size() == 0) begin
                    m_armed = 0;
                    e_under = 1;
                end else begin
                    v = m_q.pop_front();
                    if (v > PERIOD - 1) v = PERIOD - 1;
                    m_target = v;
                    m_armed  = 1;
                    if (loop_mode) m_q.push_back(v);
                end
            end else begin
                m_phase++;
            end
            if (m_armed && m_phase == m_target) begin
                e_spike = 1;
                m_armed = 0;
                m_fired = 1;
                m_tx    = m_target;
            end
        end
        if (acc) m_q.push_back(int'(wr_phase));
        m_acc = acc;
    endfunction

    task automatic step();
        @(negedge clk);
        if (rst_n) chk("wr_ready", 32'(wr_ready), 32'(model_ready()));
        @(posedge clk);
        model_step();
        #1;
        chk("global_phase", 32'(global_phase), m_phase);
        chk("cycle_start", 32'(cycle_start), 32'(e_cs));
        chk("spike_out", 32'(spike_out), 32'(e_spike));
        chk("fired_this_cycle", 32'(fired_this_cycle), 32'(m_fired));
        chk("phase_tx", 32'(phase_tx), m_tx);
        chk("fifo_count", 32'(fifo_count), m_q.size());
        chk("underrun", 32'(underrun), 32'(e_under));
        if (spike_out === 1'b1) begin
            sp_phase.push_back(int'(global_phase));
            sp_cs.push_back(cycle_start);
        end
        if (underrun === 1'b1) n_under_seen++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        loop_mode = 1'b0;
        wr_valid  = 1'b0;
        wr_phase  = 8'd0;
        step();
        rst_n = 1'b1;
        sp_phase.delete();
        sp_cs.delete();
        n_under_seen = 0;
    endtask

    task automatic push(input int v);
        int k;
        k        = 0;
        wr_valid = 1'b1;
        wr_phase = 8'(v);
        do begin
            step();
            k++;
        end while (!m_acc && k < 600);
        if (!m_acc) begin
            n_chk++;
            n_err++;
            $display("FAIL push_timeout value=%0d actual=not_accepted required=accepted", v);
        end
        wr_valid = 1'b0;
    endtask

    task automatic chk_spikes(input string nm, input int exp[$]);
        chk({nm, "_count"}, sp_phase.size(), exp.size());
        for (int i = 0; i < exp.size() && i < sp_phase.size(); i++) begin
            chk({nm, "_phase"}, sp_phase[i], exp[i]);
        end
    endtask

    initial begin
        int k;
        int hi;
        bit got;
        n_chk = 0;
        n_err = 0;
        tbl[0] = '{8'd0,   0,   1'b1};
        tbl[1] = '{8'd3,   3,   1'b0};
        tbl[2] = '{8'd77,  77,  1'b0};
        tbl[3] = '{8'd128, 128, 1'b0};
        tbl[4] = '{8'd200, 200, 1'b0};
        tbl[5] = '{8'd254, 254, 1'b0};
        tbl[6] = '{8'd255, 255, 1'b0};
        tbl[7] = '{8'd17,  17,  1'b0};
        model_reset();

        // T1: simple two-entry sequence, then underrun
        do_reset();
        chk("t1_rst_phase", 32'(global_phase), 255);
        chk("t1_rst_wr_ready", 32'(wr_ready), 1);
        chk("t1_rst_count", 32'(fifo_count), 0);
        chk("t1_rst_phase_tx", 32'(phase_tx), 0);
        push(1);
        push(40);
        chk("t1_count_loaded", 32'(fifo_count), 2);
        enable = 1'b1;
        step();
        chk("t1_first_cs", 32'(cycle_start), 1);
        chk("t1_first_phase", 32'(global_phase), 0);
        chk("t1_count_after_pop", 32'(fifo_count), 1);
        run(3 * PERIOD - 1);
        chk_spikes("t1_spikes", '{1, 40});
        chk("t1_underruns", n_under_seen, 1);
        chk("t1_phase_tx_end", 32'(phase_tx), 40);

        // T2: loop mode replays the sequence with writes blocked
        do_reset();
        push(1);
        push(40);
        loop_mode = 1'b1;
        enable    = 1'b1;
        hi        = 0;
        for (int i = 0; i < 6 * PERIOD; i++) begin
            step();
            if (wr_ready !== 1'b0) hi++;
            if (fifo_count !== 4'd2) hi++;
        end
        chk("t2_ready_or_count_bad", hi, 0);
        chk_spikes("t2_spikes", '{1, 40, 1, 40, 1, 40});

        // T3: boundary targets 0 and PERIOD-1
        do_reset();
        push(0);
        push(255);
        enable = 1'b1;
        step();
        chk("t3_cs_with_spike", 32'(cycle_start), 1);
        chk("t3_spike_at_zero", 32'(spike_out), 1);
        chk("t3_fired_at_zero", 32'(fired_this_cycle), 1);
        run(2 * PERIOD - 1);
        chk("t3_last_spike", 32'(spike_out), 1);
        chk("t3_last_phase", 32'(global_phase), 255);
        chk("t3_fired_last", 32'(fired_this_cycle), 1);
        step();
        chk("t3_fired_clears", 32'(fired_this_cycle), 0);
        chk("t3_underrun", 32'(underrun), 1);
        chk_spikes("t3_spikes", '{0, 255});

        // T4: full FIFO, ninth write lands on the pop edge
        do_reset();
        for (int i = 0; i < 8; i++) push(int'(tbl[i].target));
        wr_valid = 1'b1;
        wr_phase = 8'd99;
        run(3);
        chk("t4_full_ready", 32'(wr_ready), 0);
        chk("t4_full_count", 32'(fifo_count), 8);
        enable = 1'b1;
        step();
        chk("t4_same_edge_count", 32'(fifo_count), 8);
        wr_valid = 1'b0;
        run(9 * PERIOD - 1);
        chk("t4_spike_total", sp_phase.size(), 9);
        for (int i = 0; i < 8 && i < sp_phase.size(); i++) begin
            chk("t4_tbl_phase", sp_phase[i], tbl[i].exp_phase);
            chk("t4_tbl_cs", 32'(sp_cs[i]), 32'(tbl[i].exp_cs));
        end
        if (sp_phase.size() > 8) chk("t4_ninth_phase", sp_phase[8], 99);

        // T5: enable pause before the target
        do_reset();
        push(30);
        enable = 1'b1;
        run(21);
        chk("t5_at_20", 32'(global_phase), 20);
        enable = 1'b0;
        run(10);
        chk("t5_hold_phase", 32'(global_phase), 20);
        chk("t5_no_spike_paused", sp_phase.size(), 0);
        enable = 1'b1;
        k      = 0;
        got    = 0;
        while (!got && k < 300) begin
            step();
            k++;
            if (spike_out === 1'b1) got = 1;
        end
        chk("t5_resume_latency", k, 10);
        chk("t5_spike_phase", 32'(global_phase), 30);

        // T6: mid-cycle reset discards pending spike and queue
        do_reset();
        push(150);
        push(5);
        push(6);
        push(7);
        enable = 1'b1;
        run(101);
        chk("t6_at_100", 32'(global_phase), 100);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_rst_count", 32'(fifo_count), 0);
        chk("t6_rst_phase", 32'(global_phase), 255);
        chk("t6_rst_spike", 32'(spike_out), 0);
        chk("t6_rst_ready", 32'(wr_ready), 1);
        sp_phase.delete();
        step();
        chk("t6_wrap_phase", 32'(global_phase), 0);
        chk("t6_wrap_cs", 32'(cycle_start), 1);
        chk("t6_wrap_underrun", 32'(underrun), 1);
        run(PERIOD - 1);
        chk("t6_no_spike", sp_phase.size(), 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(9) != 0);
            if ($urandom_range(299) == 0) loop_mode = ~loop_mode;
            wr_valid = ($urandom_range(3) == 0);
            wr_phase = 8'($urandom_range(255));
            rst_n    = ($urandom_range(1499) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
